// File: rtl/if_stage_bp_pkg.sv
// Shared definitions for the branch-predicting fetch stage: reset PC, counter
// encodings, IF-to-IPD payload and index-width derivation.
package if_stage_bp_pkg;

    localparam int          PC_W            = 32;
    localparam logic [31:0] RESET_PC_DEF    = 32'h1c000000;
    localparam int          BTB_ENTRIES_DEF = 16;
    localparam int          TAG_W_DEF       = 8;

    typedef enum logic [1:0] {
        CNT_SNT = 2'd0,
        CNT_WNT = 2'd1,
        CNT_WT  = 2'd2,
        CNT_ST  = 2'd3
    } cnt_e;

    typedef struct packed {
        logic [PC_W-1:0] pred_pc;
        logic [PC_W-1:0] pc;
        logic            pred_taken;
    } if_ipd_t;

    function automatic int idx_w(input int entries);
        return $clog2(entries);
    endfunction

    function automatic cnt_e cnt_inc(input cnt_e c);
        return (c == CNT_ST) ? CNT_ST : cnt_e'(c + 2'd1);
    endfunction

    function automatic cnt_e cnt_dec(input cnt_e c);
        return (c == CNT_SNT) ? CNT_SNT : cnt_e'(c - 2'd1);
    endfunction

endpackage

// File: rtl/if_stage_bp_if.sv
// Fetch-stage bus: redirect, BTB training, instruction RAM and IF-to-IPD handshake.
// master = the fetch stage, slave = its surroundings.
interface if_stage_bp_if;
    import if_stage_bp_pkg::*;

    logic            redirect_valid;
    logic [PC_W-1:0] redirect_pc;
    logic            upd_valid;
    logic [PC_W-1:0] upd_pc;
    logic            upd_taken;
    logic [PC_W-1:0] upd_target;
    logic            inst_ram_en;
    logic [PC_W-1:0] inst_ram_addr;
    logic [3:0]      inst_ram_w_en;
    logic [PC_W-1:0] inst_ram_w_data;
    logic            IPD_allow_in;
    logic            IF_to_IPD_valid;
    logic [PC_W-1:0] IF_to_IPD_pc;
    logic [PC_W-1:0] IF_to_IPD_pred_pc;
    logic            IF_to_IPD_pred_taken;

    modport master (
        input  redirect_valid, redirect_pc, upd_valid, upd_pc, upd_taken, upd_target,
        input  IPD_allow_in,
        output inst_ram_en, inst_ram_addr, inst_ram_w_en, inst_ram_w_data,
        output IF_to_IPD_valid, IF_to_IPD_pc, IF_to_IPD_pred_pc, IF_to_IPD_pred_taken
    );

    modport slave (
        output redirect_valid, redirect_pc, upd_valid, upd_pc, upd_taken, upd_target,
        output IPD_allow_in,
        input  inst_ram_en, inst_ram_addr, inst_ram_w_en, inst_ram_w_data,
        input  IF_to_IPD_valid, IF_to_IPD_pc, IF_to_IPD_pred_pc, IF_to_IPD_pred_taken
    );

endinterface

// File: rtl/if_btb.sv
// Direct-mapped BTB with combinational lookup and registered training.
// IF_BHT_COUNTER_EN adds 2-bit saturating direction counters; without it a hit predicts taken.
module if_btb
    import if_stage_bp_pkg::*;
#(
    parameter int BTB_ENTRIES = BTB_ENTRIES_DEF,
    parameter int TAG_W       = TAG_W_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [PC_W-1:0] i_lk_pc,
    output logic            o_pred_taken,
    output logic [PC_W-1:0] o_target,
    input  logic            i_upd_valid,
    input  logic [PC_W-1:0] i_upd_pc,
    input  logic            i_upd_taken,
    input  logic [PC_W-1:0] i_upd_target
);
    localparam int IDX_W = idx_w(BTB_ENTRIES);

    logic [BTB_ENTRIES-1:0] r_valid;
    logic [TAG_W-1:0]       r_tag    [BTB_ENTRIES];
    logic [PC_W-1:0]        r_target [BTB_ENTRIES];

    logic [IDX_W-1:0] w_lidx, w_uidx;
    logic [TAG_W-1:0] w_ltag, w_utag;
    logic             w_lhit, w_uhit;
    logic             w_unused;

    assign w_lidx   = i_lk_pc[IDX_W+1:2];
    assign w_ltag   = i_lk_pc[IDX_W+2 +: TAG_W];
    assign w_uidx   = i_upd_pc[IDX_W+1:2];
    assign w_utag   = i_upd_pc[IDX_W+2 +: TAG_W];
    assign w_lhit   = r_valid[w_lidx] & (r_tag[w_lidx] == w_ltag);
    assign w_uhit   = r_valid[w_uidx] & (r_tag[w_uidx] == w_utag);
    assign o_target = r_target[w_lidx];
    assign w_unused = ^{i_lk_pc, i_upd_pc};

`ifdef IF_BHT_COUNTER_EN
    cnt_e r_cnt [BTB_ENTRIES];
    cnt_e w_lcnt;

    assign w_lcnt       = r_cnt[w_lidx];
    assign o_pred_taken = w_lhit & ((w_lcnt == CNT_WT) | (w_lcnt == CNT_ST));
`else
    assign o_pred_taken = w_lhit;
`endif

    // Only valid bits and counters need reset; tag/target are qualified by valid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= '0;
`ifdef IF_BHT_COUNTER_EN
            for (int i = 0; i < BTB_ENTRIES; i++) r_cnt[i] <= CNT_WNT;
`endif
        end else if (i_upd_valid) begin
`ifdef IF_BHT_COUNTER_EN
            if (w_uhit) begin
                r_cnt[w_uidx] <= i_upd_taken ? cnt_inc(r_cnt[w_uidx]) : cnt_dec(r_cnt[w_uidx]);
            end else if (i_upd_taken) begin
                r_valid[w_uidx] <= 1'b1;
                r_cnt[w_uidx]   <= CNT_WT;
            end
`else
            if (i_upd_taken)  r_valid[w_uidx] <= 1'b1;
            else if (w_uhit)  r_valid[w_uidx] <= 1'b0;
`endif
        end
    end

    // A taken resolve either refreshes the target of a hit or allocates the slot.
    always_ff @(posedge clk) begin
        if (i_upd_valid && i_upd_taken) begin
            r_tag[w_uidx]    <= w_utag;
            r_target[w_uidx] <= i_upd_target;
        end
    end

endmodule

// File: rtl/if_stage_bp.sv
// Fetch stage with BTB-based next-PC prediction and redirect override.
// Define IF_BHT_COUNTER_EN to enable 2-bit direction counters in the BTB.
module if_stage_bp
    import if_stage_bp_pkg::*;
#(
    parameter int          BTB_ENTRIES = BTB_ENTRIES_DEF,
    parameter int          TAG_W       = TAG_W_DEF,
    parameter logic [31:0] RESET_PC    = RESET_PC_DEF
) (
    input  logic          clk,
    input  logic          reset,
    if_stage_bp_if.master bus
);
    logic [PC_W-1:0] r_pc;
    logic            r_valid;

    logic            w_allow_in;
    logic            w_pred_taken;
    logic [PC_W-1:0] w_target;
    logic [PC_W-1:0] w_pred_pc;
    logic [PC_W-1:0] w_next_pc;
    if_ipd_t         w_out;

    if_btb #(
        .BTB_ENTRIES (BTB_ENTRIES),
        .TAG_W       (TAG_W)
    ) u_btb (
        .clk          (clk),
        .reset        (reset),
        .i_lk_pc      (r_pc),
        .o_pred_taken (w_pred_taken),
        .o_target     (w_target),
        .i_upd_valid  (bus.upd_valid),
        .i_upd_pc     (bus.upd_pc),
        .i_upd_taken  (bus.upd_taken),
        .i_upd_target (bus.upd_target)
    );

    assign w_allow_in = ~r_valid | bus.IPD_allow_in;
    assign w_pred_pc  = w_pred_taken ? w_target : r_pc + 32'd4;
    assign w_next_pc  = bus.redirect_valid ? bus.redirect_pc : w_pred_pc;

    // RAM is only read when the fetch will be consumed, so a stall keeps its word.
    assign bus.inst_ram_en     = ~reset & (w_allow_in | bus.redirect_valid);
    assign bus.inst_ram_addr   = w_next_pc;
    assign bus.inst_ram_w_en   = 4'b0;
    assign bus.inst_ram_w_data = '0;

    assign w_out = '{pred_pc: w_pred_pc, pc: r_pc, pred_taken: w_pred_taken};
    assign bus.IF_to_IPD_valid      = r_valid;
    assign bus.IF_to_IPD_pc         = w_out.pc;
    assign bus.IF_to_IPD_pred_pc    = w_out.pred_pc;
    assign bus.IF_to_IPD_pred_taken = w_out.pred_taken;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc    <= RESET_PC - 32'd4;
            r_valid <= 1'b0;
        end else if (bus.redirect_valid) begin
            r_pc    <= bus.redirect_pc;
            r_valid <= 1'b1;
        end else if (w_allow_in) begin
            r_pc    <= w_pred_pc;
            r_valid <= 1'b1;
        end
    end

endmodule

// File: tb/tb_if_stage_bp.sv
// Scoreboard bench for if_stage_bp: a queue/array reference model predicts each
// cycle's state, handshake transfers and RAM reads; an independent monitor checks them.
module tb_if_stage_bp;
    import if_stage_bp_pkg::*;

    localparam int          ENT = 16;
    localparam int          TW  = 8;
    localparam int          IW  = 4;
    localparam logic [31:0] RST = 32'h1c000000;
    localparam logic [31:0] A   = 32'h1c000010;
    localparam logic [31:0] T   = 32'h1c000100;

    logic clk = 1'b0;
    logic reset = 1'b1;

    if_stage_bp_if bus();

    if_stage_bp #(.BTB_ENTRIES(ENT), .TAG_W(TW), .RESET_PC(RST)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct { bit v; logic [31:0] pc; } st_t;
    typedef struct { logic [31:0] pc; logic [31:0] pp; bit pt; } xf_t;
    typedef struct { bit v; int unsigned tag; logic [31:0] tgt; int cnt; } ent_t;

    st_t         stq[$];
    xf_t         xq[$];
    logic [31:0] rq[$];

    ent_t        btb[ENT];
    logic [31:0] m_pc;
    bit          m_valid;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic miss(input string nm);
        total++;
        bad++;
        $display("FAIL %s: DUT output with no expected entry at %0t", nm, $time);
    endtask

    function automatic int unsigned idx_of(input logic [31:0] pc);
        return (pc >> 2) % ENT;
    endfunction

    function automatic int unsigned tag_of(input logic [31:0] pc);
        return (pc >> (IW + 2)) % (1 << TW);
    endfunction

    function automatic void predict(input logic [31:0] pc, output bit pt, output logic [31:0] pp);
        int unsigned i;
        bit hit;
        i   = idx_of(pc);
        hit = btb[i].v && (btb[i].tag == tag_of(pc));
`ifdef IF_BHT_COUNTER_EN
        pt = hit && (btb[i].cnt >= 2);
`else
        pt = hit;
`endif
        pp = pt ? btb[i].tgt : pc + 32'd4;
    endfunction

    function automatic void train(input logic [31:0] pc, input bit taken, input logic [31:0] tgt);
        int unsigned i;
        bit hit;
        i   = idx_of(pc);
        hit = btb[i].v && (btb[i].tag == tag_of(pc));
`ifdef IF_BHT_COUNTER_EN
        if (hit && taken) begin
            btb[i].cnt = (btb[i].cnt == 3) ? 3 : btb[i].cnt + 1;
            btb[i].tgt = tgt;
        end else if (hit) begin
            btb[i].cnt = (btb[i].cnt == 0) ? 0 : btb[i].cnt - 1;
        end else if (taken) begin
            btb[i] = '{1'b1, tag_of(pc), tgt, 2};
        end
`else
        if (taken)    btb[i] = '{1'b1, tag_of(pc), tgt, 0};
        else if (hit) btb[i].v = 1'b0;
`endif
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < ENT; i++) begin
            btb[i].v   = 1'b0;
            btb[i].cnt = 1;
        end
        m_pc    = RST - 32'd4;
        m_valid = 1'b0;
    endfunction

    // One clock of stimulus: drive inputs, then record what the spec says must happen.
    task automatic step(input bit rv, input logic [31:0] rpc, input bit al,
                        input bit uv, input logic [31:0] upc, input bit ut, input logic [31:0] utg);
        bit          pt;
        bit          allow;
        logic [31:0] pp;
        @(negedge clk);
        reset              = 1'b0;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        bus.IPD_allow_in   = al;
        bus.upd_valid      = uv;
        bus.upd_pc         = upc;
        bus.upd_taken      = ut;
        bus.upd_target     = utg;
        predict(m_pc, pt, pp);
        allow = !m_valid || al;
        stq.push_back(st_t'{m_valid, m_pc});
        if (m_valid && al) xq.push_back(xf_t'{m_pc, pp, pt});
        if (allow || rv)   rq.push_back(rv ? rpc : pp);
        if (uv) train(upc, ut, utg);
        if (rv) begin
            m_pc    = rpc;
            m_valid = 1'b1;
        end else if (allow) begin
            m_pc    = pp;
            m_valid = 1'b1;
        end
    endtask

    task automatic run(input bit al);
        step(1'b0, 32'h0, al, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic redir(input logic [31:0] a);
        step(1'b1, a, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic upd(input logic [31:0] pc, input bit t, input logic [31:0] tg);
        step(1'b0, 32'h0, 1'b1, 1'b1, pc, t, tg);
    endtask

    function automatic logic [31:0] rnd_pc();
        return RST + ($urandom_range(0, 63) << 2);
    endfunction

    // Monitor: consumes expectations whenever the DUT presents state, a transfer or a read.
    initial begin
        st_t s;
        xf_t x;
        forever begin
            @(negedge clk);
            #1;
            if (!reset) begin
                if (stq.size() == 0) miss("state");
                else begin
                    s = stq.pop_front();
                    chk("if_valid", {31'b0, bus.IF_to_IPD_valid}, {31'b0, s.v});
                    if (s.v) chk("if_pc", bus.IF_to_IPD_pc, s.pc);
                end
                if (bus.IF_to_IPD_valid && bus.IPD_allow_in) begin
                    if (xq.size() == 0) miss("xfer");
                    else begin
                        x = xq.pop_front();
                        chk("xfer_pc", bus.IF_to_IPD_pc, x.pc);
                        chk("xfer_pred_pc", bus.IF_to_IPD_pred_pc, x.pp);
                        chk("xfer_pred_taken", {31'b0, bus.IF_to_IPD_pred_taken}, {31'b0, x.pt});
                    end
                end
                if (bus.inst_ram_en) begin
                    if (rq.size() == 0) miss("ram_read");
                    else chk("ram_addr", bus.inst_ram_addr, rq.pop_front());
                end
                chk("ram_w_en", {28'b0, bus.inst_ram_w_en}, 32'h0);
                chk("ram_w_data", bus.inst_ram_w_data, 32'h0);
            end
        end
    end

    initial begin
        bit          rv, al, uv, ut, pt;
        logic [31:0] rpc, upc, utg, pp;

        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.upd_valid      = 1'b0;
        bus.upd_pc         = 32'h0;
        bus.upd_taken      = 1'b0;
        bus.upd_target     = 32'h0;
        bus.IPD_allow_in   = 1'b1;
        model_reset();

        @(negedge clk);
        #1;
        chk("rst_valid", {31'b0, bus.IF_to_IPD_valid}, 32'h0);
        chk("rst_ram_en", {31'b0, bus.inst_ram_en}, 32'h0);
        chk("rst_ram_addr", bus.inst_ram_addr, RST);

        // sequential fetch from the reset PC
        run(1'b1); run(1'b1); run(1'b1);

        // train taken, then refetch: target follows with no bubble
        upd(A, 1'b1, T);
        redir(A); run(1'b1); run(1'b1);

        // repeated not-taken training at the same branch
        for (int k = 0; k < 3; k++) begin
            upd(A, 1'b0, 32'h0);
            redir(A); run(1'b1);
        end

        // retrain, then stall for three cycles and redirect during the stall
        upd(A, 1'b1, T); upd(A, 1'b1, T);
        redir(A); run(1'b0); run(1'b0); run(1'b0);
        step(1'b1, 32'h1c000200, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        run(1'b1); run(1'b1);

        // redirect beats a predicted-taken hit
        redir(A);
        step(1'b1, 32'h1c000300, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        run(1'b1);

        // same-cycle lookup and update of one index
        redir(A);
        step(1'b0, 32'h0, 1'b1, 1'b1, A, 1'b0, 32'h0);
        run(1'b1);
        redir(A); run(1'b1); run(1'b1);

        // 32-bit PC wrap
        redir(32'hFFFFFFFC); run(1'b1); run(1'b1);

        // asynchronous reset in the middle of a stall
        upd(A, 1'b1, T); upd(A, 1'b1, T);
        redir(A); run(1'b0);
        #3;
        reset = 1'b1;
        model_reset();
        #1;
        predict(m_pc, pt, pp);
        chk("async_rst_valid", {31'b0, bus.IF_to_IPD_valid}, 32'h0);
        chk("async_rst_ram_en", {31'b0, bus.inst_ram_en}, 32'h0);
        chk("async_rst_ram_addr", bus.inst_ram_addr, pp);
        @(posedge clk);
        run(1'b1); run(1'b1);
        redir(A); run(1'b1); run(1'b1);

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            rv  = ($urandom_range(0, 7) == 0);
            rpc = rnd_pc();
            al  = ($urandom_range(0, 3) != 0);
            uv  = ($urandom_range(0, 2) == 0);
            upc = $urandom_range(0, 1) ? m_pc : rnd_pc();
            ut  = $urandom_range(0, 1);
            utg = rnd_pc();
            step(rv, rpc, al, uv, upc, ut, utg);
        end

        #2;
        chk("state_q_left", stq.size(), 32'h0);
        chk("xfer_q_left", xq.size(), 32'h0);
        chk("ram_q_left", rq.size(), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
